// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS fetch slice.
// Contents: pcsource encodings, the NOP instruction word, and the fetch state type.
package pipe_pkg;

    // Next-PC select codes driven by the ID stage
    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // S_REQ: fetching from memory; S_FULL: fetched word held in ins_buf during a stall
    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_FULL = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pcsource   in  2   target select from ID
//   redirect   in  1   a redirect is being taken this cycle
//   redir_pend in  1   a redirect was taken earlier and is still waiting for its delay slot
//   redir_tgt  in  32  target captured by the pending redirect
//   pc         in  32  current fetch PC
//   bpc/da/jpc in  32  branch, register-jump and jump targets
//   pc_plus4   out 32  pc + 4 (wraps modulo 2^32)
//   target     out 32  target selected by pcsource
//   npc        out 32  PC to load when the current instruction is consumed
module pipe_npc_mux
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic        redirect,
    input  logic        redir_pend,
    input  logic [31:0] redir_tgt,
    input  logic [31:0] pc,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic [31:0] npc
);

    always_comb begin
        pc_plus4 = pc + 32'd4;
        case (pcsource)
            PCS_BR:  target = bpc;
            PCS_JR:  target = da;
            PCS_J:   target = jpc;
            default: target = pc_plus4;
        endcase
        // A live redirect wins over an older pending one
        if (redirect)
            npc = target;
        else if (redir_pend)
            npc = redir_tgt;
        else
            npc = pc_plus4;
    end

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage feeding the IF/ID register of the 5-stage MIPS pipeline.
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   wpcir                 ID stall: IF/ID holds, nothing is consumed
//   pcsource, bpc, da, jpc next-PC select and targets from ID
//   imem_req/addr/ack/rdata variable-latency instruction memory handshake
//   pc4, ins, ins_valid   instruction presented to IF/ID (bubble: 0, NOP_INST, 0)
module pipeif_fetch
    import pipe_pkg::fetch_state_t;
    import pipe_pkg::S_REQ;
    import pipe_pkg::S_FULL;
    import pipe_pkg::PCS_SEQ;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        ins_valid
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  ins_buf, ins_buf_nx;
    logic [31:0]  redir_tgt, redir_tgt_nx;
    logic         redir_pend, redir_pend_nx;

    logic         redirect;
    logic         consume;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic [31:0]  npc;

    // The instruction in IF is the delay slot of any redirect seen while ID is not stalled
    assign redirect = (pcsource != PCS_SEQ) & ~wpcir;
    assign consume  = ins_valid & ~wpcir;

    pipe_npc_mux u_npc (
        .pcsource   (pcsource),
        .redirect   (redirect),
        .redir_pend (redir_pend),
        .redir_tgt  (redir_tgt),
        .pc         (pc),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .pc_plus4   (pc_plus4),
        .target     (target),
        .npc        (npc)
    );

    // Presented instruction; memory data bypasses straight through on a same-cycle ack
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        ins       = NOP_INST;
        pc4       = 32'd0;
        ins_valid = 1'b0;
        if (!reset) begin
            if (state == S_REQ) begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ins       = imem_rdata;
                    pc4       = pc_plus4;
                    ins_valid = 1'b1;
                end
            end else begin
                ins       = ins_buf;
                pc4       = pc_plus4;
                ins_valid = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        ins_buf_nx    = ins_buf;
        redir_pend_nx = redir_pend;
        redir_tgt_nx  = redir_tgt;
        if (consume) begin
            pc_nx         = npc;
            state_nx      = S_REQ;
            redir_pend_nx = 1'b0;
        end else if ((state == S_REQ) && imem_ack && wpcir) begin
            ins_buf_nx = imem_rdata;
            state_nx   = S_FULL;
        end
        // Delay slot not yet delivered: remember where to go after it
        if (redirect && !consume) begin
            redir_pend_nx = 1'b1;
            redir_tgt_nx  = target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            ins_buf    <= 32'd0;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'd0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            ins_buf    <= ins_buf_nx;
            redir_pend <= redir_pend_nx;
            redir_tgt  <= redir_tgt_nx;
        end
    end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Randomized scoreboard bench for pipeif_fetch.
module tb_pipeif_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, da, jpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc4, ins;
    logic        ins_valid;

    pipeif_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc4        (pc4),
        .ins        (ins),
        .ins_valid  (ins_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: address of each instruction in expected delivery order
    logic [31:0] q[$];

    // ---------------- Reference model: architectural fetch order ----------------
    logic [31:0] cur_m;
    logic        pend_m;
    logic [31:0] ptgt_m;

    always @(negedge clock) begin
        logic        redir;
        logic [31:0] tgt;
        if (reset) begin
            q.delete();
            q.push_back(RESET_PC);
            cur_m  = RESET_PC;
            pend_m = 1'b0;
            ptgt_m = 32'd0;
        end else begin
            redir = (pcsource != 2'b00) && !wpcir;
            case (pcsource)
                2'b01:   tgt = bpc;
                2'b10:   tgt = da;
                2'b11:   tgt = jpc;
                default: tgt = cur_m + 32'd4;
            endcase
            if (ins_valid && !wpcir) begin
                if (redir)       cur_m = tgt;
                else if (pend_m) cur_m = ptgt_m;
                else             cur_m = cur_m + 32'd4;
                q.push_back(cur_m);
                pend_m = 1'b0;
            end else if (redir) begin
                pend_m = 1'b1;
                ptgt_m = tgt;
            end
        end
    end

    // ---------------- Monitor ----------------
    logic held_m = 1'b0;
    int   idle   = 0;

    always @(negedge clock) begin
        logic [31:0] a;
        if (reset) begin
            chk(imem_req == 1'b0, "rst_req", 32'(imem_req), 32'd0);
            chk(ins_valid == 1'b0, "rst_valid", 32'(ins_valid), 32'd0);
            chk(ins == 32'd0, "rst_ins", ins, 32'd0);
            chk(pc4 == 32'd0, "rst_pc4", pc4, 32'd0);
            held_m = 1'b0;
            idle   = 0;
        end else if (q.size() == 0) begin
            chk(1'b0, "sb_empty", 32'd0, 32'd1);
        end else begin
            a = q[0];
            chk(ins_valid == (imem_ack | held_m), "valid", 32'(ins_valid), 32'(imem_ack | held_m));
            chk(imem_req == !held_m, "req", 32'(imem_req), 32'(!held_m));
            if (imem_req)
                chk(imem_addr == a, "addr", imem_addr, a);
            if (ins_valid) begin
                chk(pc4 == a + 32'd4, "pc4", pc4, a + 32'd4);
                chk(ins == memf(a), "ins", ins, memf(a));
            end else begin
                chk(ins == 32'd0, "bubble_ins", ins, 32'd0);
                chk(pc4 == 32'd0, "bubble_pc4", pc4, 32'd0);
            end
            if (ins_valid && !wpcir) begin
                void'(q.pop_front());
                held_m = 1'b0;
                idle   = 0;
            end else begin
                if (ins_valid) held_m = 1'b1;
                idle++;
                if (idle > 40) begin
                    chk(1'b0, "progress_timeout", 32'(idle), 32'd40);
                    idle = 0;
                end
            end
        end
    end

    // ---------------- Stimulus and memory ----------------
    int   lat_mode = 0;  // 0: zero-wait, 1: one wait cycle, 2: random 0..2
    int   br_pct   = 0;
    int   st_pct   = 0;
    logic rst_req  = 1'b1;
    logic need_new = 1'b1;
    int   lat_left = 0;

    function automatic logic [31:0] pick_tgt();
        if ($urandom_range(7) == 0)
            return 32'hFFFF_FFFC;
        return $urandom & 32'h0000_0FFC;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        reset    = rst_req;
        wpcir    = ($urandom_range(99) < st_pct);
        pcsource = ($urandom_range(99) < br_pct) ? 2'($urandom_range(3)) : 2'b00;
        bpc      = pick_tgt();
        da       = pick_tgt();
        jpc      = pick_tgt();
        #1;
        if (!reset && imem_req) begin
            if (need_new) begin
                lat_left = (lat_mode == 0) ? 0 : (lat_mode == 1) ? 1 : int'($urandom_range(2));
                need_new = 1'b0;
            end
            if (lat_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                need_new   = 1'b1;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                lat_left--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            need_new   = 1'b1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        wpcir      = 1'b0;
        pcsource   = 2'b00;
        bpc        = 32'd0;
        da         = 32'd0;
        jpc        = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;

        repeat (3) step();
        rst_req = 1'b0;
        // Zero-wait, no stalls, sequential
        repeat (20) step();
        // One wait cycle per fetch
        lat_mode = 1;
        repeat (20) step();
        // Zero-wait with frequent stalls
        lat_mode = 0; st_pct = 50;
        repeat (40) step();
        // Everything random, with branches
        lat_mode = 2; st_pct = 30; br_pct = 30;
        repeat (1000) step();
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;
        repeat (1000) step();
        // Branch-heavy, rare stalls
        br_pct = 70; st_pct = 10;
        repeat (500) step();

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS computer. It sits directly upstream of the IF/ID pipeline register and drives its pc4/ins inputs. It owns the PC, selects the next PC from the ID-stage pcsource, honours the wpcir stall, and talks to a variable-latency instruction memory over a req/ack handshake. When no instruction is available it issues NOP bubbles (ins = 0).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word presented when no valid instruction is available (sll $0,$0,0)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
wpcir  in  1  stall from ID hazard unit; 1 = IF/ID holds, no consumption this cycle
pcsource  in  2  next-PC select for the instruction in ID: 00 pc+4, 01 bpc, 10 da, 11 jpc
bpc  in  32  branch target
da  in  32  register-jump target (jr)
jpc  in  32  jump target (j/jal)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word-aligned PC)
imem_ack  in  1  memory data valid this cycle; legal only while imem_req=1; may be same-cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
pc4  out  32  PC+4 of the presented instruction, or 0 on a bubble
ins  out  32  presented instruction, or NOP_INST on a bubble
ins_valid  out  1  1 when ins is a fetched instruction, 0 on a bubble

Behaviour:
- Registers: pc[31:0], state {S_REQ, S_FULL}, ins_buf[31:0], redir_pend, redir_tgt[31:0].
- Reset (reset=1 at posedge): pc<=RESET_PC, state<=S_REQ, ins_buf<=0, redir_pend<=0, redir_tgt<=0. While reset=1: imem_req=0, ins=NOP_INST, pc4=0, ins_valid=0.
- S_REQ: imem_req=1, imem_addr=pc, held stable until ack. If imem_ack=1: ins=imem_rdata, pc4=pc+4, ins_valid=1 (combinational bypass); otherwise a bubble.
- S_FULL: imem_req=0, ins=ins_buf, pc4=pc+4, ins_valid=1.
- consume = ins_valid & ~wpcir. On consume: pc<=npc, state<=S_REQ, redir_pend<=0.
- S_REQ with ack and wpcir=1: ins_buf<=imem_rdata, state<=S_FULL, pc unchanged.
- Redirect (delayed-branch semantics): redirect = (pcsource!=00) & ~wpcir. The instruction in IF, or the one currently being fetched, is the delay slot and is always delivered.
- Next-PC selection: npc = redirect ? target(pcsource) : redir_pend ? redir_tgt : pc+4.
- Pending redirect: redirect & ~consume sets redir_pend<=1 and redir_tgt<=target(pcsource). Redirect in the same cycle as consume uses the target directly and leaves redir_pend=0.
- Redirect while redir_pend=1 (branch in delay slot, architecturally undefined): the newer target overwrites.
- PC arithmetic is 32-bit and wraps modulo 2^32 (pc=FFFF_FFFC gives pc4=0). Targets are used as-is, with no alignment check.
- Throughput: a zero-wait memory (same-cycle ack) with no stalls gives 1 instruction per cycle. Each memory wait cycle produces 1 bubble.
- Memory contract: the memory abandons any outstanding request when imem_req drops. imem_req drops only under reset or in S_FULL, and in S_FULL no request is outstanding.

Decomposition:
- Shared package pipe_pkg: pcsource encodings (PCS_SEQ=2'b00, PCS_BR=2'b01, PCS_JR=2'b10, PCS_J=2'b11), NOP_INST constant, fetch state enum.
- One sub-module is natural: pipe_npc_mux, a combinational mux covering target select, pending-redirect select and pc+4.

Test Plan:
- Reset, zero-wait memory, wpcir=0: addresses 0,4,8,C on consecutive cycles; ins tracks memory, pc4=4,8,C,10, ins_valid=1 from the first cycle after reset release.
- 2-cycle-latency memory (ack on the 2nd req cycle): each instruction is preceded by exactly 1 bubble (ins=0, pc4=0, ins_valid=0); imem_addr is stable while waiting.
- Ack with wpcir=1 for 3 cycles: state S_FULL, imem_req=0, ins held at the buffered word. On wpcir=0 it is consumed, and the next cycle shows imem_addr=pc+4.
- pcsource=01, bpc=0x100 with the delay slot at 0x8 being acked the same cycle: 0x8 is delivered, then the next imem_addr=0x100.
- pcsource=11, jpc=0x200 while the delay-slot fetch at 0xC is still waiting: redir_pend=1. When 0xC is acked and consumed, the next imem_addr=0x200 and redir_pend clears.
- Reset asserted mid-fetch at pc=0x40: imem_req=0 during reset. After release, imem_addr=RESET_PC and redir_pend=0; a late ack is ignored.
